// File: rtl/ifetch_wb_if.sv
// ifetch_wb_if
//   Wishbone classic instruction-port bundle between the fetch stage
//   (master) and the NoC instruction slave.
//
//   wbm_adr_o  32  fetch address, word aligned
//   wbm_cyc_o   1  cycle
//   wbm_stb_o   1  strobe (always equal to cyc)
//   wbm_we_o    1  write enable, always 0
//   wbm_sel_o   4  byte selects, always 4'hF
//   wbm_dat_i  32  read data
//   wbm_ack_i   1  transfer acknowledge
//   wbm_err_i   1  bus error
interface ifetch_wb_if;
    logic [31:0] wbm_adr_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/ifetch_wb.sv
// ifetch_wb
//   RV32I instruction fetch stage. Wishbone classic read master feeding a
//   small prefetch FIFO of {pc, inst, err}; the FIFO head is offered to
//   decode over a valid/ready handshake. A redirect from execute flushes
//   the FIFO and restarts fetch at the (word-aligned) target.
//
//   Parameters
//     RESET_PC    first fetch address after reset
//     FIFO_DEPTH  prefetch entries, power of 2, >= 2
//
//   Ports
//     clk            clock, rising edge
//     rst_n          synchronous active-low reset
//     wbm            Wishbone master bundle (ifetch_wb_if.master)
//     redirect_i     one-cycle redirect pulse from execute
//     redirect_pc_i  redirect target, bits [1:0] ignored
//     inst_valid_o   FIFO head valid
//     inst_ready_i   decode accepts the head
//     inst_o         head instruction, NOP (32'h13) when empty
//     pc_o           head PC, 0 when empty
//     fetch_err_o    head entry came from an errored transfer
//
//   Build option
//     IFETCH_BUS_ERR_EN  when defined, wbm_err_i terminates a transfer and
//                        pushes a NOP entry flagged with err; otherwise
//                        wbm_err_i is ignored and fetch_err_o is 0.
//
//   state | meaning
//   IDLE  | no bus cycle, waiting for FIFO space
//   REQ   | cyc/stb high at fetch_pc
//   DRAIN | cyc/stb held for a transfer whose data is discarded
module ifetch_wb #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ifetch_wb_if.master        wbm,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [31:0]        inst_o,
    output logic [31:0]        pc_o,
    output logic               fetch_err_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        adr_q;
    logic               cyc_q;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;

    logic [31:0]        pc_mem   [FIFO_DEPTH];
    logic [31:0]        inst_mem [FIFO_DEPTH];

    logic               bus_err;
    logic               term;
    logic               push;
    logic               pop;
    logic               space;
    logic [31:0]        wdata;
    logic [31:0]        target;

`ifdef IFETCH_BUS_ERR_EN
    logic err_mem [FIFO_DEPTH];

    assign bus_err = wbm.wbm_err_i;

    always_ff @(posedge clk) begin
        if (push) begin
            err_mem[wr_ptr] <= bus_err;
        end
    end

    assign fetch_err_o = inst_valid_o & err_mem[rd_ptr];
`else
    logic unused_err;

    assign bus_err     = 1'b0;
    assign unused_err  = wbm.wbm_err_i;
    assign fetch_err_o = 1'b0;
`endif

    assign term   = wbm.wbm_ack_i | bus_err;
    // A redirect discards both the acked word and any pop in the same cycle.
    assign push   = (state == REQ) & term & ~redirect_i;
    assign pop    = inst_valid_o & inst_ready_i & ~redirect_i;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    assign space  = (count_nxt < DEPTH_C);
    assign wdata  = bus_err ? NOP : wbm.wbm_dat_i;
    assign target = {redirect_pc_i[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= wdata;
        end
    end

    // adr_q is kept apart from fetch_pc so the address stays stable while a
    // discarded transfer drains after a redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            adr_q    <= RESET_PC;
            cyc_q    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= target;
            cyc_q    <= 1'b1;
            if (state == IDLE || term) begin
                state <= REQ;
                adr_q <= target;
            end else begin
                state <= DRAIN;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            case (state)
                IDLE: begin
                    if (space) begin
                        state <= REQ;
                        cyc_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (term) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        adr_q    <= fetch_pc + 32'd4;
                        if (!space) begin
                            state <= IDLE;
                            cyc_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (term) begin
                        adr_q <= fetch_pc;
                        state <= space ? REQ : IDLE;
                        cyc_q <= space;
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = 1'b0;
    assign wbm.wbm_sel_o = 4'hF;

    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : NOP;
    assign pc_o         = inst_valid_o ? pc_mem[rd_ptr]   : 32'h0;
endmodule

// File: tb/tb_ifetch_wb.sv
// Directed bench for ifetch_wb. Slave returns 32'hC0DE_0000 | adr[15:0]
// after ws wait states; err is pulsed on err_addr at the first cycle.
module tb_ifetch_wb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ready;
   logic        valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        ferr;

   int          ws;
   int          wcnt = 0;
   logic        err_en;
   logic [31:0] err_addr;
   logic        err_now;
   logic        err_term;

   int checks = 0;
   int errors = 0;

   ifetch_wb_if bus ();

   ifetch_wb dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wbm           (bus),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .inst_valid_o  (valid),
      .inst_ready_i  (ready),
      .inst_o        (inst),
      .pc_o          (pc),
      .fetch_err_o   (ferr)
   );

   always #5 clk = ~clk;

   assign err_now = err_en & bus.wbm_cyc_o & bus.wbm_stb_o
                    & (bus.wbm_adr_o == err_addr) & (wcnt == 0);
`ifdef IFETCH_BUS_ERR_EN
   assign err_term = err_now;
`else
   assign err_term = 1'b0;
`endif
   assign bus.wbm_err_i = err_now;
   assign bus.wbm_ack_i = bus.wbm_cyc_o & bus.wbm_stb_o & (wcnt >= ws);
   assign bus.wbm_dat_i = 32'hC0DE_0000 | {16'h0, bus.wbm_adr_o[15:0]};

   always @(posedge clk) begin
      if (!bus.wbm_stb_o || bus.wbm_ack_i || err_term) wcnt <= 0;
      else                                               wcnt <= wcnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
      ws = 0; err_en = 1'b0; err_addr = 32'h0;
      step(); step();
      chk("rst_cyc",   bus.wbm_cyc_o, 1'b0);
      chk("rst_stb",   bus.wbm_stb_o, 1'b0);
      chk("rst_adr",   bus.wbm_adr_o, 32'h0);
      chk("rst_we",    bus.wbm_we_o,  1'b0);
      chk("rst_sel",   bus.wbm_sel_o, 4'hF);
      chk("rst_valid", valid, 1'b0);
      chk("rst_inst",  inst, 32'h13);
      chk("rst_pc",    pc,   32'h0);
      chk("rst_ferr",  ferr, 1'b0);

      // streaming, zero-wait slave, decode always ready
      rst_n = 1'b1;
      step();
      chk("a1_cyc",   bus.wbm_cyc_o, 1'b1);
      chk("a1_stb",   bus.wbm_stb_o, 1'b1);
      chk("a1_adr",   bus.wbm_adr_o, 32'h0);
      chk("a1_valid", valid, 1'b0);
      step();
      chk("a2_valid", valid, 1'b1);
      chk("a2_pc",    pc,    32'h0);
      chk("a2_inst",  inst,  32'hC0DE_0000);
      chk("a2_adr",   bus.wbm_adr_o, 32'h4);
      step();
      chk("a3_pc",   pc,   32'h4);
      chk("a3_inst", inst, 32'hC0DE_0004);
      chk("a3_adr",  bus.wbm_adr_o, 32'h8);
      step();
      chk("a4_pc",  pc, 32'h8);
      chk("a4_adr", bus.wbm_adr_o, 32'hC);

      // reset in the middle of a REQ with a valid entry
      rst_n = 1'b0; ready = 1'b0;
      step();
      chk("mr_cyc",   bus.wbm_cyc_o, 1'b0);
      chk("mr_valid", valid, 1'b0);
      chk("mr_adr",   bus.wbm_adr_o, 32'h0);
      chk("mr_inst",  inst, 32'h13);
      chk("mr_pc",    pc,   32'h0);

      // backpressure: two acks fill the FIFO then stb drops
      rst_n = 1'b1;
      step();
      chk("b1_cyc", bus.wbm_cyc_o, 1'b1);
      chk("b1_adr", bus.wbm_adr_o, 32'h0);
      step();
      chk("b2_valid", valid, 1'b1);
      chk("b2_pc",    pc, 32'h0);
      chk("b2_adr",   bus.wbm_adr_o, 32'h4);
      step();
      chk("b3_cyc", bus.wbm_cyc_o, 1'b0);
      chk("b3_stb", bus.wbm_stb_o, 1'b0);
      chk("b3_adr", bus.wbm_adr_o, 32'h8);
      chk("b3_pc",  pc, 32'h0);
      step();
      chk("b4_cyc",   bus.wbm_cyc_o, 1'b0);
      chk("b4_valid", valid, 1'b1);
      chk("b4_pc",    pc, 32'h0);
      ready = 1'b1;
      step();
      chk("b5_cyc",  bus.wbm_cyc_o, 1'b1);
      chk("b5_adr",  bus.wbm_adr_o, 32'h8);
      chk("b5_pc",   pc, 32'h4);
      chk("b5_inst", inst, 32'hC0DE_0004);
      step();
      chk("b6_pc",   pc, 32'h8);
      chk("b6_inst", inst, 32'hC0DE_0008);
      chk("b6_adr",  bus.wbm_adr_o, 32'hC);

      // 3 wait states, redirect mid-transfer -> DRAIN
      ws = 3;
      step();
      chk("c1_valid", valid, 1'b0);
      chk("c1_adr",   bus.wbm_adr_o, 32'hC);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      step();
      redirect = 1'b0;
      chk("c2_cyc",   bus.wbm_cyc_o, 1'b1);
      chk("c2_adr",   bus.wbm_adr_o, 32'hC);
      chk("c2_valid", valid, 1'b0);
      step();
      chk("c3_adr",   bus.wbm_adr_o, 32'hC);
      chk("c3_valid", valid, 1'b0);
      step();
      chk("c4_adr",   bus.wbm_adr_o, 32'h100);
      chk("c4_cyc",   bus.wbm_cyc_o, 1'b1);
      chk("c4_valid", valid, 1'b0);
      step(); step(); step();
      chk("c7_valid", valid, 1'b0);
      chk("c7_adr",   bus.wbm_adr_o, 32'h100);
      step();
      chk("c8_valid", valid, 1'b1);
      chk("c8_pc",    pc, 32'h100);
      chk("c8_inst",  inst, 32'hC0DE_0100);
      chk("c8_adr",   bus.wbm_adr_o, 32'h104);

      // redirect coinciding with ack and pop
      ws = 0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      chk("d1_valid", valid, 1'b0);
      chk("d1_inst",  inst, 32'h13);
      chk("d1_pc",    pc, 32'h0);
      chk("d1_adr",   bus.wbm_adr_o, 32'h200);
      chk("d1_cyc",   bus.wbm_cyc_o, 1'b1);
      step();
      chk("d2_pc",   pc, 32'h200);
      chk("d2_inst", inst, 32'hC0DE_0200);
      chk("d2_adr",  bus.wbm_adr_o, 32'h204);

      // redirect from IDLE, target low bits forced to zero
      ready = 1'b0;
      step();
      chk("d3_cyc", bus.wbm_cyc_o, 1'b0);
      chk("d3_adr", bus.wbm_adr_o, 32'h208);
      chk("d3_pc",  pc, 32'h200);
      redirect = 1'b1; redirect_pc = 32'h0000_0032;
      step();
      redirect = 1'b0; ready = 1'b1;
      chk("d4_cyc",   bus.wbm_cyc_o, 1'b1);
      chk("d4_adr",   bus.wbm_adr_o, 32'h30);
      chk("d4_valid", valid, 1'b0);
      step();
      chk("d5_valid", valid, 1'b1);
      chk("d5_pc",    pc, 32'h30);
      chk("d5_inst",  inst, 32'hC0DE_0030);

      // bus error on address 0x4, one wait state
      rst_n = 1'b0;
      step();
      err_en = 1'b1; err_addr = 32'h4; ws = 1; rst_n = 1'b1;
      step(); step(); step();
      chk("e3_adr",  bus.wbm_adr_o, 32'h4);
      chk("e3_pc",   pc, 32'h0);
      chk("e3_ferr", ferr, 1'b0);
      step();
`ifdef IFETCH_BUS_ERR_EN
      chk("e4_valid", valid, 1'b1);
      chk("e4_pc",    pc, 32'h4);
      chk("e4_inst",  inst, 32'h13);
      chk("e4_ferr",  ferr, 1'b1);
      chk("e4_adr",   bus.wbm_adr_o, 32'h8);
      step();
      chk("e5_adr",   bus.wbm_adr_o, 32'h8);
      chk("e5_valid", valid, 1'b0);
`else
      chk("e4_valid", valid, 1'b0);
      chk("e4_adr",   bus.wbm_adr_o, 32'h4);
      chk("e4_cyc",   bus.wbm_cyc_o, 1'b1);
      step();
      chk("e5_valid", valid, 1'b1);
      chk("e5_pc",    pc, 32'h4);
      chk("e5_inst",  inst, 32'hC0DE_0004);
      chk("e5_ferr",  ferr, 1'b0);
      chk("e5_adr",   bus.wbm_adr_o, 32'h8);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
